uart_rx: RTL and testbench

//  UART receiver; sits downstream of the UART transmitter on the serial line.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sampler.sv | 53 +++++
 rtl/uart_rx.sv | 143 ++++++++++++++
 tb/tb_uart_rx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default oversampling rate
// and the parity rule common to transmitter and receiver.
package uart_pkg;

  localparam int unsigned OsRateDefault = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

  // Parity bit value for a data byte: par_typ=1 gives the XOR of the bits,
  // par_typ=0 its complement.
  function automatic logic calc_parity(input logic [7:0] data, input logic par_typ);
    return par_typ ? (^data) : (~^data);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority vote around the bit centre.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned OS_RATE = OsRateDefault
) (
  input  logic                       clk_in,
  input  logic                       rst,
  input  logic                       run,
  input  logic                       rx_s,
  output logic [$clog2(OS_RATE)-1:0] edge_cnt,
  output logic                       bit_done,
  output logic                       bit_val
);

  localparam int unsigned CW = $clog2(OS_RATE);
  localparam int unsigned H  = OS_RATE / 2;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    smp_q;
  logic          third;

  // Counter runs while a frame is active and returns to 0 otherwise, so the
  // start-detect cycle is always edge_cnt 0.
  always_comb begin
    cnt_d = '0;
    if (run) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter and sample registers.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      cnt_q <= '0;
      smp_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (cnt_q == CW'(H - 1)) smp_q[0] <= rx_s;
      if (cnt_q == CW'(H))     smp_q[1] <= rx_s;
      if (cnt_q == CW'(H + 1)) smp_q[2] <= rx_s;
    end
  end

  // Third sample is taken live at H+1 so the vote is usable in that cycle.
  always_comb begin
    third    = (cnt_q == CW'(H + 1)) ? rx_s : smp_q[2];
    bit_val  = (smp_q[0] & smp_q[1]) | (smp_q[0] & third) | (smp_q[1] & third);
    bit_done = (cnt_q == CW'(OS_RATE - 1));
    edge_cnt = cnt_q;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchroniser, frame FSM, shift register and output pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OS_RATE = OsRateDefault
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       par_en,
  input  logic       par_typ,
  output logic [7:0] p_data,
  output logic       data_valid,
  output logic       par_err,
  output logic       stp_err,
  output logic       busy
);

  localparam int unsigned CW = $clog2(OS_RATE);
  localparam int unsigned H  = OS_RATE / 2;

  logic [1:0]    sync_q;
  logic          rx_s, rx_prev_q, start_det;
  uart_state_e   state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic          par_bad_q, par_bad_d;
  logic [7:0]    p_data_q, p_data_d;
  logic          dv_q, dv_d, pe_q, pe_d, se_q, se_d;
  logic          frame_ok;
  logic [CW-1:0] edge_cnt;
  logic          bit_done, bit_val, mid;

  assign rx_s      = sync_q[1];
  assign start_det = rx_prev_q & ~rx_s;
  assign mid       = (edge_cnt == CW'(H + 1));

  uart_rx_sampler #(
    .OS_RATE(OS_RATE)
  ) u_sampler (
    .clk_in  (clk_in),
    .rst     (rst),
    .run     (state_d != StIdle),
    .rx_s    (rx_s),
    .edge_cnt(edge_cnt),
    .bit_done(bit_done),
    .bit_val (bit_val)
  );

  // Frame sequencing; outcome is decided at the stop-bit vote and shows up
  // the cycle after, when the FSM is already back in idle.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_bad_d = par_bad_q;
    p_data_d  = p_data_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;
    frame_ok  = bit_val & ~par_bad_q;
    unique case (state_q)
      StIdle: begin
        if (start_det) begin
          state_d   = StStart;
          par_en_d  = par_en;
          par_typ_d = par_typ;
          bit_cnt_d = '0;
          par_bad_d = 1'b0;
        end
      end
      StStart: begin
        if (mid && bit_val) begin
          state_d = StIdle;
        end else if (bit_done) begin
          state_d = StData;
        end
      end
      StData: begin
        if (mid) shift_d = {bit_val, shift_q[7:1]};
        if (bit_done) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = par_en_q ? StParity : StStop;
        end
      end
      StParity: begin
        if (mid) par_bad_d = (bit_val != calc_parity(shift_q, par_typ_q));
        if (bit_done) state_d = StStop;
      end
      StStop: begin
        if (mid) begin
          state_d = StIdle;
          se_d    = ~bit_val;
          pe_d    = par_bad_q;
          dv_d    = frame_ok;
          if (frame_ok) p_data_d = shift_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, datapath and output registers; reset also discards a partial frame.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad_q <= 1'b0;
      p_data_q  <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx_in};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_bad_q <= par_bad_d;
      p_data_q  <= p_data_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  assign p_data     = p_data_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: builds a full line waveform up front, predicts every
// output cycle with a frame-level model, then replays and compares each cycle.
module tb_uart_rx;

  localparam int unsigned OsRate = 8;
  localparam int unsigned H      = OsRate / 2;
  localparam int          MaxCyc = 16384;

  logic       clk_in = 1'b0;
  logic       rst, rx_in, par_en, par_typ;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err, busy;

  uart_rx #(
    .OS_RATE(OsRate)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .rx_in     (rx_in),
    .par_en    (par_en),
    .par_typ   (par_typ),
    .p_data    (p_data),
    .data_valid(data_valid),
    .par_err   (par_err),
    .stp_err   (stp_err),
    .busy      (busy)
  );

  always #5 clk_in = ~clk_in;

  // Stimulus per cycle n (driven just after posedge n).
  bit         stim_rx[MaxCyc];
  bit         stim_rst[MaxCyc];
  bit         stim_pe[MaxCyc];
  bit         stim_pt[MaxCyc];
  // Model view of the synchronised line and expected outputs in cycle n.
  bit         rxs[MaxCyc];
  bit         exp_dv[MaxCyc];
  bit         exp_pe[MaxCyc];
  bit         exp_se[MaxCyc];
  bit         exp_busy[MaxCyc];
  logic [7:0] exp_pd[MaxCyc];
  bit         ld[MaxCyc];
  logic [7:0] ld_val[MaxCyc];

  int wp;
  int num_cyc;
  int checks;
  int errors;
  int pin_cyc[$];
  int pin_kind[$];
  int pin_val[$];

  // Reset is in effect during cycle m when rst was low at posedge m.
  function automatic bit rst_at(input int m);
    if (m <= 0) return 1'b1;
    return !stim_rst[m-1];
  endfunction

  function automatic bit par_bit(input logic [7:0] d, input bit pt);
    bit odd;
    odd = ($countones(d) % 2) == 1;
    return pt ? odd : !odd;
  endfunction

  function automatic bit vote(input int t0, input int k);
    int b;
    b = t0 + k * OsRate;
    return (int'(rxs[b+H-1]) + int'(rxs[b+H]) + int'(rxs[b+H+1])) >= 2;
  endfunction

  task automatic put(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      if (wp < MaxCyc) stim_rx[wp] = v;
      wp++;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pe, input bit pt, input bit flip,
                            input bit stop, output int c);
    c = wp;
    stim_pe[c+2] = pe;
    stim_pt[c+2] = pt;
    put(1'b0, OsRate);
    for (int i = 0; i < 8; i++) put(d[i], OsRate);
    if (pe) put(par_bit(d, pt) ^ flip, OsRate);
    put(stop, OsRate);
  endtask

  task automatic pin(input int cyc, input int kind, input int val);
    pin_cyc.push_back(cyc);
    pin_kind.push_back(kind);
    pin_val.push_back(val);
  endtask

  task automatic check1(input string name, input int n, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, n, got, want);
    end
  endtask

  // Frame-level prediction straight from the line waveform.
  task automatic run_model();
    int         idle_from, t0, k_stop, fin, r, last;
    bit         abort, pe_l, pt_l, par_ok, stop_ok;
    logic [7:0] d;
    logic [7:0] pd;
    for (int m = 0; m < num_cyc; m++) begin
      if (m < 2 || rst_at(m) || rst_at(m - 1)) rxs[m] = 1'b1;
      else rxs[m] = stim_rx[m-2];
    end
    idle_from = 0;
    for (int n = 1; n < num_cyc; n++) begin
      if (rst_at(n) || n < idle_from) continue;
      if (!(rxs[n-1] && !rxs[n])) continue;
      t0      = n;
      pe_l    = stim_pe[t0];
      pt_l    = stim_pt[t0];
      abort   = vote(t0, 0);
      d       = '0;
      par_ok  = 1'b1;
      stop_ok = 1'b1;
      if (abort) begin
        fin = t0 + H + 2;
      end else begin
        k_stop = pe_l ? 10 : 9;
        fin    = t0 + k_stop * OsRate + H + 2;
        if (fin >= num_cyc) break;
        for (int i = 0; i < 8; i++) d[i] = vote(t0, i + 1);
        if (pe_l) par_ok = (vote(t0, 9) == par_bit(d, pt_l));
        stop_ok = vote(t0, k_stop);
      end
      if (fin >= num_cyc) break;
      r = 0;
      for (int m = t0 + 1; m <= fin; m++) if (r == 0 && rst_at(m)) r = m;
      last = (r != 0) ? r : fin;
      for (int m = t0 + 1; m < last; m++) exp_busy[m] = 1'b1;
      if (!abort && r == 0) begin
        exp_dv[fin] = par_ok && stop_ok;
        exp_pe[fin] = !par_ok;
        exp_se[fin] = !stop_ok;
        if (par_ok && stop_ok) begin
          ld[fin]     = 1'b1;
          ld_val[fin] = d;
        end
      end
      idle_from = last;
    end
    pd = '0;
    for (int m = 0; m < num_cyc; m++) begin
      if (rst_at(m)) pd = '0;
      else if (ld[m]) pd = ld_val[m];
      exp_pd[m] = pd;
    end
  endtask

  initial begin
    int         c, c2, sel, pos, nbits;
    logic [7:0] d;
    bit         pe, pt, flip, stop;
    int         got;
    string      kname;

    checks = 0;
    errors = 0;
    wp     = 0;
    for (int i = 0; i < MaxCyc; i++) begin
      stim_rx[i]  = 1'b1;
      stim_rst[i] = 1'b1;
      stim_pe[i]  = 1'($urandom);
      stim_pt[i]  = 1'($urandom);
    end
    for (int i = 0; i < 5; i++) stim_rst[i] = 1'b0;
    put(1'b1, 20);

    // Clean frame, no parity: pulse 78 cycles after start detect (c+2).
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, c);
    pin(c + 80, 0, 1); pin(c + 80, 3, 8'hA5); pin(c + 80, 1, 0); pin(c + 80, 2, 0);
    pin(c + 79, 0, 0); pin(c + 3, 4, 1);
    put(1'b1, 10);
    // Parity frames, odd-type with even ones: good then corrupted.
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, c);
    pin(c + 88, 0, 1); pin(c + 88, 3, 8'h3C);
    put(1'b1, 10);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, c);
    pin(c + 88, 1, 1); pin(c + 88, 0, 0);
    put(1'b1, 10);
    // Start glitch: 3 low cycles abort.
    c = wp;
    put(1'b0, 3);
    put(1'b1, 20);
    pin(c + 3, 4, 1); pin(c + 2 + H + 2, 4, 0);
    // Single-cycle glitch on the centre sample of data bit 2.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, c);
    stim_rx[c + 3 * OsRate + H] = ~stim_rx[c + 3 * OsRate + H];
    pin(c + 80, 0, 1); pin(c + 80, 3, 8'h55);
    put(1'b1, 10);
    // Stop bit low followed by a long break.
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, c);
    put(1'b0, 40 * OsRate);
    put(1'b1, 24);
    pin(c + 80, 2, 1); pin(c + 80, 0, 0); pin(c + 80, 3, 8'h55); pin(c + 280, 4, 0);
    // Back-to-back frames.
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, c);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, c2);
    pin(c + 80, 0, 1); pin(c + 80, 3, 8'h01); pin(c2 + 80, 0, 1); pin(c2 + 80, 3, 8'hFF);
    put(1'b1, 10);
    // Reset during data bit 4 of a frame, then a clean frame.
    c = wp;
    put(1'b0, OsRate);
    d = 8'h7E;
    for (int i = 0; i < 5; i++) put(d[i], OsRate);
    stim_rst[c + 44] = 1'b0;
    pin(c + 44, 4, 1); pin(c + 45, 4, 0); pin(c + 45, 3, 0);
    put(1'b1, 30);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, c);
    pin(c + 80, 0, 1); pin(c + 80, 3, 8'h7E);
    put(1'b1, 10);

    // Randomised traffic.
    repeat (70) begin
      if (wp < MaxCyc - 1200) begin
        sel = $urandom_range(0, 9);
        if (sel == 0) begin
          put(1'b0, $urandom_range(1, 6));
          put(1'b1, $urandom_range(2, 12));
        end else begin
          if (sel == 1) stim_rst[wp + $urandom_range(10, 90)] = 1'b0;
          d     = 8'($urandom);
          pe    = 1'($urandom);
          pt    = 1'($urandom);
          flip  = ($urandom_range(0, 5) == 0);
          stop  = ($urandom_range(0, 7) != 0);
          send_frame(d, pe, pt, flip, stop, c);
          nbits = pe ? 11 : 10;
          if ($urandom_range(0, 2) == 0) begin
            pos = $urandom_range(0, nbits * OsRate - 1);
            stim_rx[c + pos] = ~stim_rx[c + pos];
          end
          put(1'b1, $urandom_range(0, 12));
        end
      end
    end
    put(1'b1, 200);
    num_cyc = (wp < MaxCyc) ? wp : MaxCyc;

    run_model();

    // Hand-computed expectations pin the model.
    foreach (pin_cyc[i]) begin
      case (pin_kind[i])
        0: begin got = int'(exp_dv[pin_cyc[i]]);   kname = "model_dv";    end
        1: begin got = int'(exp_pe[pin_cyc[i]]);   kname = "model_parerr"; end
        2: begin got = int'(exp_se[pin_cyc[i]]);   kname = "model_stperr"; end
        3: begin got = int'(exp_pd[pin_cyc[i]]);   kname = "model_pdata";  end
        default: begin got = int'(exp_busy[pin_cyc[i]]); kname = "model_busy"; end
      endcase
      check1(kname, pin_cyc[i], got, pin_val[i]);
    end

    rst     = 1'b0;
    rx_in   = 1'b1;
    par_en  = 1'b0;
    par_typ = 1'b0;
    for (int n = 0; n < num_cyc; n++) begin
      @(posedge clk_in);
      #1;
      rst     = stim_rst[n];
      rx_in   = stim_rx[n];
      par_en  = stim_pe[n];
      par_typ = stim_pt[n];
      @(negedge clk_in);
      check1("data_valid", n, int'(data_valid), int'(exp_dv[n]));
      check1("par_err", n, int'(par_err), int'(exp_pe[n]));
      check1("stp_err", n, int'(stp_err), int'(exp_se[n]));
      check1("busy", n, int'(busy), int'(exp_busy[n]));
      check1("p_data", n, int'(p_data), int'(exp_pd[n]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
